io_ports: RTL

IO_PORTS -- requirements
Module: io_ports

---
 rtl/io_pkg.sv | 23 ++
 rtl/io_sync2.sv | 26 ++
 rtl/io_ports.sv | 134 +++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared register-map constants for the io_ports memory-mapped I/O block.
package io_pkg;

   localparam int WIN_SIZE = 64;

   localparam logic [5:0] OFS_OUT  = 6'h00;
   localparam logic [5:0] OFS_IN   = 6'h10;
   localparam logic [5:0] OFS_STAT = 6'h20;
   localparam logic [5:0] OFS_MASK = 6'h21;
   localparam logic [5:0] OFS_ID   = 6'h22;

   // Change detection stays off until the counter reaches this value after reset.
   localparam logic [1:0] SETTLE_DONE = 2'd3;

   function automatic logic [7:0] id_byte(input int num_out, input int num_in);
      logic [3:0] o_nib;
      logic [3:0] i_nib;
      o_nib = 4'(num_out - 1);
      i_nib = 4'(num_in - 1);
      return {o_nib, i_nib};
   endfunction

endpackage

// File: rtl/io_sync2.sv
// Parametrised-width two-flop synchronizer for asynchronous input buses.
module io_sync2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/io_ports.sv
// Memory-mapped output/input port block with a 64-byte register window.
// Define IO_PORTS_IRQ_EN to build the input change-detect interrupt logic.
module io_ports
   import io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h8400,
   parameter int          NUM_OUT   = 4,
   parameter int          NUM_IN    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          addr,
   input  logic [7:0]           data_in,
   input  logic                 write_enable,
   output logic [7:0]           data_out,
   output logic                 sel_out,
   output logic [8*NUM_OUT-1:0] port_out,
   input  logic [8*NUM_IN-1:0]  port_in,
   output logic                 irq
);

   logic              hit;
   logic [5:0]        ofs;
   logic              wr_hit;
   logic [7:0]        out_reg [NUM_OUT];
   logic [8*NUM_IN-1:0] in_sync;
   logic [7:0]        stat_val;
   logic [7:0]        mask_val;
   logic [7:0]        rd_data;
   logic [7:0]        data_out_reg;
   logic              sel_out_reg;

   assign hit    = (addr[15:6] == BASE_ADDR[15:6]);
   assign ofs    = addr[5:0];
   assign wr_hit = write_enable && hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
         always_ff @(posedge clk) begin
            if (reset)
               out_reg[gi] <= 8'h00;
            else if (wr_hit && (ofs == OFS_OUT + 6'(gi)))
               out_reg[gi] <= data_in;
         end
         assign port_out[8*gi +: 8] = out_reg[gi];
      end
   endgenerate

   io_sync2 #(.WIDTH(8*NUM_IN)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (port_in),
      .q     (in_sync)
   );

`ifdef IO_PORTS_IRQ_EN
   logic [8*NUM_IN-1:0] prev_reg;
   logic [1:0]          settle_reg;
   logic [7:0]          stat_reg;
   logic [7:0]          mask_reg;
   logic                irq_reg;
   logic [7:0]          chg_set;
   logic [7:0]          stat_clr;

   // Ports beyond 7 share the top status bit.
   always_comb begin
      chg_set = 8'h00;
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_sync[8*i +: 8] != prev_reg[8*i +: 8])
            chg_set[(i > 7) ? 7 : i] = 1'b1;
      end
   end

   assign stat_clr = (wr_hit && (ofs == OFS_STAT)) ? data_in : 8'h00;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg   <= '0;
         settle_reg <= 2'd0;
         stat_reg   <= 8'h00;
         mask_reg   <= 8'h00;
         irq_reg    <= 1'b0;
      end else begin
         prev_reg <= in_sync;
         if (settle_reg != SETTLE_DONE)
            settle_reg <= settle_reg + 2'd1;
         // A new change beats a simultaneous write-1-to-clear.
         stat_reg <= (stat_reg & ~stat_clr) |
                     ((settle_reg == SETTLE_DONE) ? chg_set : 8'h00);
         if (wr_hit && (ofs == OFS_MASK))
            mask_reg <= data_in;
         irq_reg <= |(stat_reg & mask_reg);
      end
   end

   assign stat_val = stat_reg;
   assign mask_val = mask_reg;
   assign irq      = irq_reg;
`else
   assign stat_val = 8'h00;
   assign mask_val = 8'h00;
   assign irq      = 1'b0;
`endif

   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (ofs == OFS_OUT + 6'(i))
            rd_data = out_reg[i];
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (ofs == OFS_IN + 6'(i))
            rd_data = in_sync[8*i +: 8];
      end
      if (ofs == OFS_STAT) rd_data = stat_val;
      if (ofs == OFS_MASK) rd_data = mask_val;
      if (ofs == OFS_ID)   rd_data = id_byte(NUM_OUT, NUM_IN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_reg <= 8'h00;
         sel_out_reg  <= 1'b0;
      end else begin
         sel_out_reg  <= hit;
         data_out_reg <= hit ? rd_data : 8'h00;
      end
   end

   assign data_out = data_out_reg;
   assign sel_out  = sel_out_reg;

endmodule
